// File: rtl/mem_harvard_arbiter.sv
// Shares one single-port memory between the instruction and data ports of a Harvard CPU.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on conflict instead of fixed data priority.
module mem_harvard_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_waitrequest,

    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,

    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   m_address_q, m_address_d;
    logic                m_read_q, m_read_d;
    logic                m_write_q, m_write_d;
    logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
    logic [BE_W-1:0]     m_byteenable_q, m_byteenable_d;
    logic [DATA_W-1:0]   i_readdata_q, i_readdata_d;
    logic [DATA_W-1:0]   d_readdata_q, d_readdata_d;

    logic                i_req;
    logic                d_req;
    logic                grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant_q = 1 means the data port was granted most recently
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_d = d_req && !(i_req && last_grant_q);
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_comb begin
        state_d        = state_q;
        m_address_d    = m_address_q;
        m_read_d       = m_read_q;
        m_write_d      = m_write_q;
        m_writedata_d  = m_writedata_q;
        m_byteenable_d = m_byteenable_q;
        i_readdata_d   = i_readdata_q;
        d_readdata_d   = d_readdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d   = last_grant_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    // a simultaneous read+write is carried out as a write
                    m_address_d    = d_address;
                    m_writedata_d  = d_writedata;
                    m_byteenable_d = d_byteenable;
                    m_write_d      = d_write;
                    m_read_d       = !d_write;
                    state_d        = BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d   = 1'b1;
`endif
                end else if (i_req) begin
                    m_address_d    = i_address;
                    m_byteenable_d = '1;
                    m_write_d      = 1'b0;
                    m_read_d       = 1'b1;
                    state_d        = BUSY_I;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d   = 1'b0;
`endif
                end
            end

            BUSY_I: begin
                if (!m_waitrequest) begin
                    i_readdata_d = m_readdata;
                    m_read_d     = 1'b0;
                    m_write_d    = 1'b0;
                    state_d      = RESP_I;
                end
            end

            BUSY_D: begin
                if (!m_waitrequest) begin
                    if (m_read_q) begin
                        d_readdata_d = m_readdata;
                    end
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = RESP_D;
                end
            end

            RESP_I, RESP_D: begin
                state_d = IDLE;
            end

            default: begin
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            m_address_q    <= '0;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            m_writedata_q  <= '0;
            m_byteenable_q <= '0;
            i_readdata_q   <= '0;
            d_readdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q   <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            m_address_q    <= m_address_d;
            m_read_q       <= m_read_d;
            m_write_q      <= m_write_d;
            m_writedata_q  <= m_writedata_d;
            m_byteenable_q <= m_byteenable_d;
            i_readdata_q   <= i_readdata_d;
            d_readdata_q   <= d_readdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    // a port is released only in its own response cycle
    assign i_waitrequest = i_req && (state_q != RESP_I);
    assign d_waitrequest = d_req && (state_q != RESP_D);

    assign i_readdata    = i_readdata_q;
    assign d_readdata    = d_readdata_q;
    assign m_address     = m_address_q;
    assign m_read        = m_read_q;
    assign m_write       = m_write_q;
    assign m_writedata   = m_writedata_q;
    assign m_byteenable  = m_byteenable_q;

endmodule

// File: tb/tb_mem_harvard_arbiter.sv
// Scoreboard bench for mem_harvard_arbiter with a stall-programmable memory model.
module tb_mem_harvard_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] i_address;
    logic        i_read;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata;
    logic        m_waitrequest;

    always #5 clk = ~clk;

    mem_harvard_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address), .i_read(i_read), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        dport;
    } mop_t;

    mop_t        mq[$];
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    mop_t        mon_e;

    int          n_chk = 0;
    int          n_fail = 0;
    int          stall_n = 0;
    int          wcnt = 0;
    int          strobe_cyc = 0;
    logic        last_d = 1'b1;
    logic [31:0] d_rd_model = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h2402_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign m_readdata    = mem_word(m_address);
    assign m_waitrequest = (m_read || m_write) && (wcnt != stall_n);

    always @(posedge clk) begin
        if (!(m_read || m_write) || !m_waitrequest) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: memory transactions and port responses
    always @(negedge clk) begin
        if (m_read || m_write) strobe_cyc++;
        if ((m_read || m_write) && !m_waitrequest) begin
            if (mq.size() == 0) begin
                check("mem_unexpected", 1, 0);
            end else begin
                mon_e = mq.pop_front();
                check("m_address", m_address, mon_e.addr);
                check("m_read", m_read, mon_e.rd);
                check("m_write", m_write, mon_e.wr);
                if (mon_e.wr) check("m_writedata", m_writedata, mon_e.wdata);
                if (mon_e.dport) check("m_byteenable", m_byteenable, mon_e.be);
            end
        end
        if (i_read && !i_waitrequest) begin
            if (iq.size() == 0) check("i_unexpected", 1, 0);
            else check("i_readdata", i_readdata, iq.pop_front());
        end
        if ((d_read || d_write) && !d_waitrequest) begin
            if (dq.size() == 0) check("d_unexpected", 1, 0);
            else check("d_readdata", d_readdata, dq.pop_front());
        end
    end

    task automatic push_mi(input logic [31:0] a);
        mq.push_back('{addr: a, rd: 1'b1, wr: 1'b0, wdata: 32'h0, be: 4'h0, dport: 1'b0});
    endtask

    task automatic push_md(input logic [31:0] a, input logic rd, input logic wr,
                           input logic [31:0] wd, input logic [3:0] be);
        mq.push_back('{addr: a, rd: rd && !wr, wr: wr, wdata: wd, be: be, dport: 1'b1});
    endtask

    task automatic do_i(input logic [31:0] a, input int lat);
        int cyc;
        i_address = a;
        i_read    = 1'b1;
        iq.push_back(mem_word(a));
        cyc = 0;
        while (cyc <= 200) begin
            @(negedge clk);
            if (!i_waitrequest) break;
            cyc++;
        end
        check("i_latency", cyc, lat);
        @(posedge clk);
        #1 i_read = 1'b0;
    endtask

    task automatic do_d(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be, input int lat);
        int cyc;
        d_address    = a;
        d_read       = rd;
        d_write      = wr;
        d_writedata  = wd;
        d_byteenable = be;
        if (!wr) d_rd_model = mem_word(a);
        dq.push_back(d_rd_model);
        cyc = 0;
        while (cyc <= 200) begin
            @(negedge clk);
            if (!d_waitrequest) break;
            cyc++;
        end
        check("d_latency", cyc, lat);
        @(posedge clk);
        #1;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic single_i(input logic [31:0] a);
        int s0;
        push_mi(a);
        last_d = 1'b0;
        s0 = strobe_cyc;
        do_i(a, 2 + stall_n);
        check("i_strobe_cycles", strobe_cyc - s0, 1 + stall_n);
    endtask

    task automatic single_d(input logic [31:0] a, input logic rd, input logic wr,
                            input logic [31:0] wd, input logic [3:0] be);
        int s0;
        push_md(a, rd, wr, wd, be);
        last_d = 1'b1;
        s0 = strobe_cyc;
        do_d(a, rd, wr, wd, be, 2 + stall_n);
        check("d_strobe_cycles", strobe_cyc - s0, 1 + stall_n);
    endtask

    task automatic conflict(input logic [31:0] ia, input logic [31:0] da, input logic rd,
                            input logic wr, input logic [31:0] wd, input logic [3:0] be);
        logic dwin;
        int   lw;
        int   ll;
`ifdef ARB_ROUND_ROBIN_EN
        dwin = !last_d;
`else
        dwin = 1'b1;
`endif
        lw = 2 + stall_n;
        ll = 5 + 2 * stall_n;
        if (dwin) begin
            push_md(da, rd, wr, wd, be);
            push_mi(ia);
        end else begin
            push_mi(ia);
            push_md(da, rd, wr, wd, be);
        end
        last_d = !dwin;
        fork
            do_i(ia, dwin ? ll : lw);
            do_d(da, rd, wr, wd, be, dwin ? lw : ll);
        join
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n      = 1'b0;
        i_address    = 32'h0000_0010;
        i_read       = 1'b1;
        d_address    = '0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        d_writedata  = '0;
        d_byteenable = '0;

        // Reset held two cycles with a pending fetch
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_read", m_read, 0);
        check("rst_m_write", m_write, 0);
        check("rst_m_address", m_address, 0);
        check("rst_i_readdata", i_readdata, 0);
        check("rst_d_readdata", d_readdata, 0);
        check("rst_i_waitrequest", i_waitrequest, 1);
        check("rst_d_waitrequest", d_waitrequest, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        last_d = 1'b1;

        // First fetch after release, zero-wait memory
        stall_n = 0;
        single_i(32'h0000_0010);
        check("i_readdata_hold", i_readdata, 32'h2402_0005);

        // Stalled partial write, then reads and a read+write collision
        stall_n = 3;
        single_d(32'h0000_1000, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        stall_n = 1;
        single_d(32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'hF);
        single_d(32'h0000_2004, 1'b1, 1'b1, 32'h1234_5678, 4'b1100);
        check("d_readdata_after_rw", d_readdata, mem_word(32'h0000_2000));
        single_i(32'h0000_0044);

        // Simultaneous requests
        stall_n = 0;
        conflict(32'h0000_0040, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 4'hF);

        // Back-to-back conflicts
        for (int k = 0; k < 4; k++) begin
            stall_n = (k >= 2) ? 2 : 0;
            conflict(32'h0000_0100 + 32'(k * 4), 32'h0000_4000 + 32'(k * 4),
                     k[0], !k[0], 32'hA500_0000 + 32'(k), 4'b0101 << k[0]);
        end

        // Reset while the data transaction is stalled
        stall_n      = 10;
        d_address    = 32'h0000_5000;
        d_byteenable = 4'hF;
        d_read       = 1'b1;
        cyc = 0;
        while (cyc <= 20) begin
            @(negedge clk);
            if (m_read) break;
            cyc++;
        end
        check("abort_reached_busy", m_read, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_m_read", m_read, 0);
        check("abort_d_waitrequest", d_waitrequest, 1);
        check("abort_d_readdata", d_readdata, 0);
        @(posedge clk);
        #1;
        d_read     = 1'b0;
        reset_n    = 1'b1;
        last_d     = 1'b1;
        d_rd_model = '0;
        @(posedge clk);
        #1;

        // Recovery after the abort
        stall_n = 0;
        single_i(32'h0000_0080);
        single_d(32'h0000_6000, 1'b1, 1'b0, 32'h0, 4'hF);

        repeat (3) @(posedge clk);
        check("mq_left", mq.size(), 0);
        check("iq_left", iq.size(), 0);
        check("dq_left", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
